// File: rtl/nand_pipe_if.sv
// Operand/result handshake bundle for nand_pipe: operand side (in_*, a, b, en, inv),
// result side (out_*, y) and the delivered-result counter.
interface nand_pipe_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] en;
    logic             inv;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic [15:0]      count;

    modport slave (
        input  in_valid, a, b, en, inv, out_ready,
        output in_ready, out_valid, y, count
    );

    modport master (
        output in_valid, a, b, en, inv, out_ready,
        input  in_ready, out_valid, y, count
    );
endinterface

// File: rtl/nand_pipe.sv
// Masked NAND/AND unit followed by a DEPTH-stage elastic pipeline with
// valid/ready on both sides and a wrapping count of delivered results.
module nand_pipe #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    nand_pipe_if.slave  bus
);
    logic [WIDTH-1:0] result;
    logic [DEPTH:0]   free;
    logic [DEPTH-1:0] advance;
    logic [DEPTH-1:0] src_valid;
    logic [WIDTH-1:0] src_data [DEPTH];

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [15:0]      count_q;
    logic [15:0]      count_d;

    assign result = bus.en & (bus.inv ? (bus.a & bus.b) : ~(bus.a & bus.b));

    // A stage is free when empty or when its content moves on this cycle; the
    // ready chain runs backwards from out_ready and never looks at in_valid.
    always_comb begin
        free         = '0;
        advance      = '0;
        free[DEPTH]  = bus.out_ready;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            advance[k] = valid_q[k] && free[k + 1];
            free[k]    = !valid_q[k] || advance[k];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign src_valid[gi] = bus.in_valid && free[0];
                assign src_data[gi]  = result;
            end else begin : g_link
                assign src_valid[gi] = valid_q[gi - 1];
                assign src_data[gi]  = data_q[gi - 1];
            end
        end
    endgenerate

    always_comb begin
        valid_d = valid_q;
        for (int k = 0; k < DEPTH; k++) begin
            data_d[k] = data_q[k];
            if (free[k]) begin
                valid_d[k] = src_valid[k];
                if (src_valid[k]) begin
                    data_d[k] = src_data[k];
                end
            end
        end
        count_d = (valid_q[DEPTH - 1] && bus.out_ready) ? count_q + 16'd1 : count_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            count_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

    // Reset forces ready high so upstream sees an empty pipe; the reset branch
    // above still prevents anything from being captured on that edge.
    assign bus.in_ready  = !rst_n || free[0];
    assign bus.out_valid = valid_q[DEPTH - 1];
    assign bus.y         = data_q[DEPTH - 1];
    assign bus.count     = count_q;
endmodule

// File: tb/tb_nand_pipe.sv
// Self-checking bench for nand_pipe (WIDTH=4, DEPTH=2): directed vectors,
// corner-case sequences and randomized traffic against a queue-based model.
module tb_nand_pipe;
    localparam int WIDTH = 4;
    localparam int DEPTH = 2;

    logic clk;
    logic rst_n;

    nand_pipe_if #(.WIDTH(WIDTH)) bus ();

    nand_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [WIDTH-1:0] d;
        int               pos;
    } item_t;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] en;
        logic             inv;
        logic [WIDTH-1:0] y;
    } vec_t;

    item_t       q[$];
    int          out_cycles[$];
    logic [15:0] mcount;
    int          tests;
    int          fails;
    int          accepted;
    int          cyc;
    bit          chk_en;

    function automatic logic [WIDTH-1:0] ref_r(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b,
                                               logic [WIDTH-1:0] en, logic inv);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            if (!en[i])   r[i] = 1'b0;
            else if (inv) r[i] = a[i] & b[i];
            else          r[i] = ~(a[i] & b[i]);
        end
        return r;
    endfunction

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Called at a falling edge with inputs applied; checks outputs, then
    // advances the model across the next rising edge.
    task automatic tick();
        logic exp_ov;
        logic exp_ir;
        bit   fire_in;
        bit   fire_out;
        int   limit;
        int   np;
        logic [WIDTH-1:0] r;
        #1;
        exp_ov = (q.size() > 0) && (q[0].pos == DEPTH - 1);
        exp_ir = !rst_n || (q.size() < DEPTH) || bus.out_ready;
        if (chk_en) begin
            check("out_valid", bus.out_valid, exp_ov);
            if (exp_ov) check("y", bus.y, q[0].d);
            check("in_ready", bus.in_ready, exp_ir);
            check("count", bus.count, mcount);
        end
        fire_in  = rst_n && bus.in_valid && exp_ir;
        fire_out = rst_n && exp_ov && bus.out_ready;
        r = ref_r(bus.a, bus.b, bus.en, bus.inv);
        if (fire_in) accepted++;
        if (fire_out) begin
            out_cycles.push_back(cyc);
            if (chk_en) $display("[TB] out y=%h count=%0d cycle=%0d", q[0].d, mcount + 16'd1, cyc);
        end
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            mcount = 16'd0;
        end else begin
            if (fire_out) begin
                void'(q.pop_front());
                mcount = mcount + 16'd1;
            end
            limit = DEPTH - 1;
            foreach (q[i]) begin
                np = q[i].pos + 1;
                if (np > limit) np = limit;
                q[i].pos = np;
                limit = np - 1;
            end
            if (fire_in) q.push_back('{d: r, pos: 0});
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic randomize_ops();
        bus.a   = WIDTH'($urandom);
        bus.b   = WIDTH'($urandom);
        bus.en  = WIDTH'($urandom);
        bus.inv = 1'($urandom);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    vec_t vec [6];
    logic [WIDTH-1:0] y_hold;
    int s;

    initial begin
        tests = 0; fails = 0; accepted = 0; cyc = 0; mcount = 16'd0; chk_en = 1'b1;
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bus.a = '0; bus.b = '0; bus.en = '0; bus.inv = 1'b0;

        vec[0] = '{a: 4'b1100, b: 4'b1010, en: 4'b1111, inv: 1'b0, y: 4'b0111};
        vec[1] = '{a: 4'b1100, b: 4'b1010, en: 4'b0101, inv: 1'b0, y: 4'b0101};
        vec[2] = '{a: 4'b1100, b: 4'b1010, en: 4'b0101, inv: 1'b1, y: 4'b0000};
        vec[3] = '{a: 4'b1111, b: 4'b1111, en: 4'b1111, inv: 1'b1, y: 4'b1111};
        vec[4] = '{a: 4'b1111, b: 4'b1111, en: 4'b1111, inv: 1'b0, y: 4'b0000};
        vec[5] = '{a: 4'b0000, b: 4'b0101, en: 4'b1010, inv: 1'b0, y: 4'b1010};

        @(negedge clk);
        tick();
        #1;
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_y", bus.y, 4'b0000);
        check("rst_count", bus.count, 16'd0);
        check("rst_in_ready", bus.in_ready, 1'b1);
        rst_n = 1'b1;

        foreach (vec[i]) begin
            bus.a = vec[i].a; bus.b = vec[i].b; bus.en = vec[i].en; bus.inv = vec[i].inv;
            bus.in_valid = 1'b1; bus.out_ready = 1'b1;
            tick();
            bus.in_valid = 1'b0;
            tick();
            check("tbl_valid", bus.out_valid, 1'b1);
            check("tbl_y", bus.y, vec[i].y);
            tick();
        end
        check("tbl_count", bus.count, 16'd6);

        // Backpressure: only DEPTH sets fit, output must hold still.
        accepted = 0;
        bus.out_ready = 1'b0; bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            randomize_ops();
            tick();
        end
        check("bp_accepted", accepted, 2);
        #1;
        check("bp_in_ready", bus.in_ready, 1'b0);
        y_hold = bus.y;
        tick();
        tick();
        check("bp_y_stable", bus.y, y_hold);
        check("bp_valid_stable", bus.out_valid, 1'b1);
        bus.out_ready = 1'b1;
        randomize_ops();
        #1;
        check("bp_ready_on_drain", bus.in_ready, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            randomize_ops();
        end
        bus.in_valid = 1'b0;
        repeat (3) tick();

        // Streaming: 10 back-to-back sets, results on consecutive cycles.
        do_reset();
        out_cycles.delete();
        s = cyc;
        bus.out_ready = 1'b1; bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            randomize_ops();
            tick();
        end
        bus.in_valid = 1'b0;
        repeat (3) tick();
        check("stream_n", out_cycles.size(), 10);
        foreach (out_cycles[i]) check("stream_cycle", out_cycles[i], s + DEPTH + i);
        check("stream_count", bus.count, 16'd10);

        // Reset with two results in flight.
        bus.out_ready = 1'b0; bus.in_valid = 1'b1;
        randomize_ops(); tick();
        randomize_ops(); tick();
        rst_n = 1'b0;
        randomize_ops();
        #1;
        check("rstmid_in_ready", bus.in_ready, 1'b1);
        tick();
        rst_n = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        check("rstmid_valid", bus.out_valid, 1'b0);
        check("rstmid_y", bus.y, 4'b0000);
        check("rstmid_count", bus.count, 16'd0);
        repeat (3) tick();
        bus.in_valid = 1'b1; randomize_ops(); tick();
        bus.in_valid = 1'b0;
        repeat (3) tick();

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            rst_n = ($urandom_range(0, 49) != 0);
            bus.in_valid  = 1'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            randomize_ops();
            tick();
        end
        rst_n = 1'b1;

        // Counter wrap after 65536 deliveries.
        do_reset();
        chk_en = 1'b0;
        out_cycles.delete();
        bus.out_ready = 1'b1; bus.in_valid = 1'b1;
        repeat (65536) tick();
        bus.in_valid = 1'b0;
        repeat (3) tick();
        chk_en = 1'b1;
        check("wrap_outs", out_cycles.size(), 65536);
        check("wrap_count", bus.count, 16'd0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
